serial_add_ctrl: RTL and testbench

- Sequencer that performs a WIDTH-bit add or subtract by reusing one 1-bit full-adder cell over WIDTH clock cycles, LSB first.
- Sits beside the ALU as the area-minimal arithmetic path for multi-cycle instructions.
- Uses a start/busy/done handshake toward the issuing control unit.
- Results are held stable until the next accepted start.

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_full_adder_bit.sv | 16 +
 rtl/serial_add_ctrl.sv | 95 +++++++++
 tb/tb_serial_add_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// One-bit full-adder cell, reused every cycle by the serial add sequencer.
// Purely combinational; the caller owns the carry flop.
module full_adder_bit (
   output logic z,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   always_comb begin
      z    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, through a single full-adder
// cell, with a start/busy/done handshake. Results hold until the next start.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic             fa_sum;
   logic             fa_cout;

   full_adder_bit u_fa (
      .z    (fa_sum),
      .cout (fa_cout),
      .a    (shift_a[0]),
      .b    (shift_b[0]),
      .cin  (carry)
   );

   // Operand shift registers carry no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         z     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shift_a <= a;
                  shift_b <= sub ? ~b : b;
                  carry   <= sub ? 1'b1 : cin;
                  cnt     <= '0;
                  z       <= '0;
                  cout    <= 1'b0;
                  ovf     <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               z       <= {fa_sum, z[WIDTH-1:1]};
               carry   <= fa_cout;
               shift_a <= shift_a >> 1;
               shift_b <= shift_b >> 1;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  // carry still holds the carry into the MSB on this edge
                  ovf   <= carry ^ fa_cout;
                  cout  <= fa_cout;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8: result values,
// latency, busy/done handshake, reset abort, start-while-busy and back-to-back.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] z;
   logic         cout;
   logic         ovf;

   int total  = 0;
   int passed = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .z     (z),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] z;
      logic         cout;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Issue one operation and follow it until busy falls (bounded).
   task automatic do_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, output int lat, output int busy_cnt,
                        output int done_cnt, output logic [W-1:0] zr,
                        output logic cr, output logic vr);
      int idx;
      @(negedge clk);
      start = 1'b1; sub = s; a = av; b = bv; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = -1; busy_cnt = 0; done_cnt = 0; zr = 'x; cr = 1'bx; vr = 1'bx;
      idx = 0;
      while (idx < 40) begin
         busy_cnt += int'(busy);
         if (done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = idx; zr = z; cr = cout; vr = ovf;
            end
         end
         if (!busy && idx > 0) break;
         @(posedge clk); #1;
         idx++;
      end
   endtask

   vec_t vecs[8];

   initial begin
      int lat, bcnt, dcnt, cyc, ndone, first, second;
      logic [W-1:0] zr, bb;
      logic cr, vr;
      logic [W:0] full;
      logic [W-1:0] ez;
      logic eo;

      vecs[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset z", z, 0);
      check("reset cout", cout, 0);
      check("reset ovf", ovf, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt, dcnt, zr, cr, vr);
         check($sformatf("vec%0d latency", i), lat, 8);
         check($sformatf("vec%0d busy cycles", i), bcnt, 9);
         check($sformatf("vec%0d done pulses", i), dcnt, 1);
         check($sformatf("vec%0d z", i), zr, vecs[i].z);
         check($sformatf("vec%0d cout", i), cr, vecs[i].cout);
         check($sformatf("vec%0d ovf", i), vr, vecs[i].ovf);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("vec%0d hold", i), {z, cout, ovf}, {vecs[i].z, vecs[i].cout, vecs[i].ovf});
      end

      // Reset abort at the 4th RUN edge
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h01; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort busy", busy, 0);
      check("abort z", z, 0);
      check("abort done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         ndone += int'(done);
      end
      check("abort no done", ndone, 0);
      do_op(1'b0, 8'h7F, 8'h01, 1'b0, lat, bcnt, dcnt, zr, cr, vr);
      check("post-abort latency", lat, 8);
      check("post-abort result", {zr, cr, vr}, {8'h80, 1'b0, 1'b1});

      // Start during RUN is ignored
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; zr = 'x; cyc = 0;
      while (busy && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin ndone++; zr = z; end
      end
      repeat (12) begin
         @(posedge clk); #1;
         ndone += int'(done);
      end
      check("busy-start done count", ndone, 1);
      check("busy-start z", zr, 8'h30);

      // start held high: back-to-back operations
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0;
      first = -1; second = -1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      @(negedge clk); start = 1'b0;
      check("b2b first done", first, 8);
      check("b2b spacing", second - first, 10);
      cyc = 0;
      while (busy && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b idle", busy, 0);

      // Random operands against an arithmetic model
      for (int i = 0; i < 200; i++) begin
         logic s, c;
         logic [W-1:0] av, bv;
         s = 1'($urandom); c = 1'($urandom);
         av = W'($urandom); bv = W'($urandom);
         if (s) begin
            bb = ~bv;
            full = {1'b0, av} + {1'b0, bb} + 9'd1;
         end else begin
            bb = bv;
            full = {1'b0, av} + {1'b0, bb} + {8'd0, c};
         end
         ez = full[W-1:0];
         eo = (av[W-1] == bb[W-1]) && (ez[W-1] != av[W-1]);
         do_op(s, av, bv, c, lat, bcnt, dcnt, zr, cr, vr);
         check($sformatf("rand%0d %s %02h %02h", i, s ? "sub" : "add", av, bv),
               {lat[7:0], zr, cr, vr}, {8'd8, ez, full[W], eo});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
